// File: rtl/relu_maxpool.sv
// Eight-channel ReLU followed by 2x2 stride-2 max pooling over a raster stream.
// One line buffer holds the horizontal maxima of each even row.
module relu_maxpool #(
    parameter int DW   = 69,
    parameter int COLS = 24,
    parameter int ROWS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic signed [DW-1:0] conv_result_1,
    input  logic signed [DW-1:0] conv_result_2,
    input  logic signed [DW-1:0] conv_result_3,
    input  logic signed [DW-1:0] conv_result_4,
    input  logic signed [DW-1:0] conv_result_5,
    input  logic signed [DW-1:0] conv_result_6,
    input  logic signed [DW-1:0] conv_result_7,
    input  logic signed [DW-1:0] conv_result_8,
    output logic signed [DW-1:0] pool_result_1,
    output logic signed [DW-1:0] pool_result_2,
    output logic signed [DW-1:0] pool_result_3,
    output logic signed [DW-1:0] pool_result_4,
    output logic signed [DW-1:0] pool_result_5,
    output logic signed [DW-1:0] pool_result_6,
    output logic signed [DW-1:0] pool_result_7,
    output logic signed [DW-1:0] pool_result_8,
    output logic                 out_valid,
    output logic [7:0]           out_idx,
    output logic                 frame_done
);

    localparam int NCH = 8;
    localparam int HC  = COLS / 2;
    localparam int CW  = (COLS > 2) ? $clog2(COLS) : 2;
    localparam int RW  = (ROWS > 2) ? $clog2(ROWS) : 2;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic [DW-1:0] x      [NCH];
    logic [DW-1:0] relu   [NCH];
    logic [DW-1:0] hmax   [NCH];
    logic [DW-1:0] lb_rd  [NCH];
    logic [DW-1:0] hold_q [NCH];
    logic [DW-1:0] hold_d [NCH];
    logic [DW-1:0] pool_q [NCH];
    logic [DW-1:0] pool_d [NCH];
    logic [DW-1:0] lb_q   [HC][NCH];

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic [CW-2:0] half_col;
    logic          odd_col, odd_row;
    logic          col_wrap, lb_we;
    logic [7:0]    out_idx_q, out_idx_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;

    assign x[0] = conv_result_1;
    assign x[1] = conv_result_2;
    assign x[2] = conv_result_3;
    assign x[3] = conv_result_4;
    assign x[4] = conv_result_5;
    assign x[5] = conv_result_6;
    assign x[6] = conv_result_7;
    assign x[7] = conv_result_8;

    // in_sof forces the sample to the frame origin, discarding any partial window
    always_comb begin
        col_eff  = in_sof ? '0 : col_q;
        row_eff  = in_sof ? '0 : row_q;
        half_col = col_eff[CW-1:1];
        odd_col  = col_eff[0];
        odd_row  = row_eff[0];
        col_wrap = (col_eff == COL_LAST);
        for (int k = 0; k < NCH; k++) begin
            relu[k]  = x[k][DW-1] ? '0 : x[k];
            hmax[k]  = (relu[k] > hold_q[k]) ? relu[k] : hold_q[k];
            lb_rd[k] = lb_q[half_col][k];
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_idx_d    = out_idx_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            hold_d[k] = hold_q[k];
            pool_d[k] = pool_q[k];
        end
        if (in_valid) begin
            col_d = col_wrap ? '0 : col_eff + 1'b1;
            if (col_wrap) begin
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
            end else begin
                row_d = row_eff;
            end
            unique case (1'b1)
                !odd_col: begin
                    for (int k = 0; k < NCH; k++) begin
                        hold_d[k] = relu[k];
                    end
                end
                odd_col && !odd_row: begin
                    lb_we = 1'b1;
                end
                odd_col && odd_row: begin
                    for (int k = 0; k < NCH; k++) begin
                        pool_d[k] = (lb_rd[k] > hmax[k]) ? lb_rd[k] : hmax[k];
                    end
                    out_idx_d    = 8'(row_eff[RW-1:1]) * 8'(HC)
                                 + 8'(half_col);
                    out_valid_d  = 1'b1;
                    frame_done_d = (row_eff == ROW_LAST) && col_wrap;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                pool_q[k] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_idx_q    <= out_idx_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < NCH; k++) begin
                pool_q[k] <= pool_d[k];
            end
        end
    end

    // window storage needs no reset: every entry is written before it is read
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                hold_q[k] <= hold_d[k];
                if (lb_we) begin
                    lb_q[half_col][k] <= hmax[k];
                end
            end
        end
    end

    assign pool_result_1 = pool_q[0];
    assign pool_result_2 = pool_q[1];
    assign pool_result_3 = pool_q[2];
    assign pool_result_4 = pool_q[3];
    assign pool_result_5 = pool_q[4];
    assign pool_result_6 = pool_q[5];
    assign pool_result_7 = pool_q[6];
    assign pool_result_8 = pool_q[7];
    assign out_valid     = out_valid_q;
    assign out_idx       = out_idx_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Self-checking bench for relu_maxpool: frame-array reference model,
// per-cycle compare, and literal pins on selected windows.
module tb_relu_maxpool;

    localparam int DW   = 69;
    localparam int COLS = 24;
    localparam int ROWS = 24;
    localparam int HC   = COLS / 2;
    localparam int NOUT = HC * (ROWS / 2);
    localparam int NCH  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic signed [DW-1:0] cin  [NCH];
    logic signed [DW-1:0] pout [NCH];
    logic       out_valid, frame_done;
    logic [7:0] out_idx;

    always #5 clk = ~clk;

    relu_maxpool #(.DW(DW), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .conv_result_1(cin[0]), .conv_result_2(cin[1]),
        .conv_result_3(cin[2]), .conv_result_4(cin[3]),
        .conv_result_5(cin[4]), .conv_result_6(cin[5]),
        .conv_result_7(cin[6]), .conv_result_8(cin[7]),
        .pool_result_1(pout[0]), .pool_result_2(pout[1]),
        .pool_result_3(pout[2]), .pool_result_4(pout[3]),
        .pool_result_5(pout[4]), .pool_result_6(pout[5]),
        .pool_result_7(pout[6]), .pool_result_8(pout[7]),
        .out_valid(out_valid), .out_idx(out_idx), .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] relu_f(input logic signed [DW-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction

    function automatic logic [DW-1:0] mx(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DW-1:0] fm [ROWS][COLS][NCH];
    logic [DW-1:0] e_pool [NCH];
    logic          e_valid = 1'b0;
    logic          e_fd = 1'b0;
    logic [7:0]    e_idx = '0;
    int            mr = 0;
    int            mc = 0;

    always @(posedge clk) begin
        if (rst) begin
            mr = 0; mc = 0;
            e_valid = 1'b0; e_fd = 1'b0; e_idx = '0;
            for (int k = 0; k < NCH; k++) e_pool[k] = '0;
        end else begin
            e_valid = 1'b0;
            e_fd = 1'b0;
            if (in_valid) begin
                if (in_sof) begin mr = 0; mc = 0; end
                for (int k = 0; k < NCH; k++) fm[mr][mc][k] = relu_f(cin[k]);
                if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                    for (int k = 0; k < NCH; k++)
                        e_pool[k] = mx(mx(fm[mr-1][mc-1][k], fm[mr-1][mc][k]),
                                       mx(fm[mr][mc-1][k], fm[mr][mc][k]));
                    e_valid = 1'b1;
                    e_idx = 8'((mr / 2) * HC + mc / 2);
                    e_fd = (mr == ROWS - 1) && (mc == COLS - 1);
                end
                mc++;
                if (mc == COLS) begin
                    mc = 0; mr++;
                    if (mr == ROWS) mr = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit            cmp_en = 1'b0;
    int            n_out, n_fd, fd_idx, nxt_idx;
    logic [DW-1:0] got1 [NOUT];
    logic [DW-1:0] got8 [NOUT];

    always @(negedge clk) begin
        if (cmp_en) begin
            chkb("out_valid", out_valid, e_valid);
            chkb("frame_done", frame_done, e_fd);
            chk("out_idx", DW'(out_idx), DW'(e_idx));
            for (int k = 0; k < NCH; k++)
                chk($sformatf("pool_%0d", k + 1), pout[k], e_pool[k]);
            if (out_valid === 1'b1) begin
                chki("idx_order", int'(out_idx), nxt_idx);
                nxt_idx = (nxt_idx + 1) % NOUT;
                if (int'(out_idx) < NOUT) begin
                    got1[out_idx] = pout[0];
                    got8[out_idx] = pout[7];
                end
                n_out++;
                if (frame_done === 1'b1) begin
                    n_fd++;
                    fd_idx = int'(out_idx);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam int M_RAND = 0, M_WIN = 1, M_NEG = 2, M_EXT = 3, M_RAMP = 4;

    function automatic logic signed [DW-1:0] sample(input int mode,
            input int r, input int c, input int k);
        logic [95:0]   rnd;
        logic [DW-1:0] t;
        rnd = {$urandom, $urandom, $urandom};
        t = '0;
        case (mode)
            M_WIN: begin
                if (k == 0 && r < 2 && c < 2) begin
                    case (r * 2 + c)
                        0: return 5;
                        1: return -3;
                        2: return 7;
                        default: return 2;
                    endcase
                end
                return rnd[DW-1:0];
            end
            M_NEG: return -100;
            M_EXT: begin
                if (k != 7 || r > 1) return 0;
                if (r == 0 && c == 2) begin t[67] = 1'b1; return t - 1'b1; end
                if (r == 1 && c == 3) begin t[68] = 1'b1; return t; end
                if (c == 4 || c == 5) begin t[68] = 1'b1; return t; end
                return 0;
            end
            M_RAMP: return DW'(r * COLS + c);
            default: return rnd[DW-1:0];
        endcase
    endfunction

    task automatic send(input bit v, input bit s, input int mode,
                        input int r, input int c);
        logic [95:0] g;
        in_valid = v;
        in_sof = s;
        for (int k = 0; k < NCH; k++) begin
            g = {$urandom, $urandom, $urandom};
            cin[k] = v ? sample(mode, r, c, k) : g[DW-1:0];
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 1'b0, M_RAND, 0, 0);
    endtask

    task automatic drive_frame(input int mode, input int duty,
                               input bit sof, input int tail);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                while ($urandom_range(99) >= duty) idle(1);
                send(1'b1, sof && r == 0 && c == 0, mode, r, c);
            end
        idle(tail);
    endtask

    task automatic partial(input int nr, input int nc);
        for (int r = 0; r <= nr; r++)
            for (int c = 0; c < COLS; c++)
                if (r < nr || c < nc) send(1'b1, 1'b0, M_RAND, r, c);
    endtask

    task automatic clr();
        n_out = 0; n_fd = 0; fd_idx = -1; nxt_idx = 0;
    endtask

    task automatic frame_stats(input string nm, input int nexp);
        chki({nm, "_n_out"}, n_out, nexp);
        chki({nm, "_n_fd"}, n_fd, nexp / NOUT);
        chki({nm, "_fd_idx"}, fd_idx, NOUT - 1);
    endtask

    logic [DW-1:0] pmax;

    initial begin
        pmax = '0;
        pmax[67] = 1'b1;
        pmax = pmax - 1'b1;
        for (int k = 0; k < NCH; k++) cin[k] = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chkb("rst_valid", out_valid, 1'b0);
        chkb("rst_fd", frame_done, 1'b0);
        chk("rst_idx", DW'(out_idx), '0);
        chk("rst_pool1", pout[0], '0);
        chk("rst_pool8", pout[7], '0);
        rst = 1'b0;

        clr();
        drive_frame(M_WIN, 100, 1'b1, 3);
        chk("win_pool1", got1[0], DW'(7));
        frame_stats("win", NOUT);

        clr();
        drive_frame(M_NEG, 100, 1'b0, 3);
        chk("neg_pool1_0", got1[0], '0);
        chk("neg_pool8_143", got8[NOUT-1], '0);
        frame_stats("neg", NOUT);

        clr();
        drive_frame(M_EXT, 100, 1'b0, 3);
        chk("ext_pmax", got8[1], pmax);
        chk("ext_neg", got8[2], '0);
        chk("ext_zero", got8[0], '0);

        clr();
        drive_frame(M_RAMP, 30, 1'b1, 3);
        chk("ramp_0", got1[0], DW'(25));
        chk("ramp_13", got1[13], DW'(75));
        chk("ramp_143", got1[NOUT-1], DW'(575));
        frame_stats("ramp", NOUT);

        partial(5, 9);
        idle(2);
        clr();
        drive_frame(M_RAND, 100, 1'b1, 3);
        frame_stats("sof_resync", NOUT);

        partial(5, 9);
        rst = 1'b1;
        send(1'b1, 1'b1, M_RAND, 0, 0);
        rst = 1'b0;
        clr();
        drive_frame(M_RAND, 60, 1'b0, 3);
        frame_stats("rst_resync", NOUT);

        clr();
        drive_frame(M_RAND, 100, 1'b0, 0);
        drive_frame(M_RAND, 100, 1'b0, 3);
        frame_stats("b2b", 2 * NOUT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_maxpool.md
RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 Parameter DW, default 69: width of each signed input/output channel word.
REQ-002 Parameter COLS, default 24: input feature-map width in samples; shall be even.
REQ-003 Parameter ROWS, default 24: input feature-map height in samples; shall be even.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port in_valid, input, 1: all eight conv_result_k hold a valid sample this cycle.
REQ-007 Port in_sof, input, 1: start of frame; qualified by in_valid.
REQ-008 Ports conv_result_1..conv_result_8, input, DW each, signed: one sample per channel, raster order.
REQ-009 Ports pool_result_1..pool_result_8, output, DW each, signed: pooled ReLU result per channel, registered.
REQ-010 Port out_valid, output, 1: one-cycle pulse; pool_result_k and out_idx valid.
REQ-011 Port out_idx, output, 8: pooled raster index, row*(COLS/2)+col, 0..143 at defaults.
REQ-012 Port frame_done, output, 1: one-cycle pulse coincident with the last out_valid of a frame.

Function
REQ-013 ReLU per channel: value = (x < 0) ? 0 : x; full DW width kept; no truncation or saturation.
REQ-014 Pooling: 2x2 window, stride 2, non-overlapping; output = max of the four ReLU values (unsigned compare after ReLU).
REQ-015 Column counter col (0..COLS-1) and row counter row (0..ROWS-1) advance only on in_valid; col wraps to 0 and row increments at COLS-1; row wraps to 0 after ROWS-1.
REQ-016 in_valid with in_sof: sample treated as row 0, col 0 regardless of counter state; partially accumulated pool windows discarded.
REQ-017 Even col: hold register per channel loads ReLU(x).
REQ-018 Odd col: horizontal max hmax = max(hold, ReLU(x)) per channel.
REQ-019 Odd col, even row: hmax written to line buffer entry col>>1 (COLS/2 entries x 8 channels x DW).
REQ-020 Odd col, odd row: pool_result_k <= max(linebuf[col>>1], hmax); out_idx <= (row>>1)*(COLS/2)+(col>>1); out_valid pulses.
REQ-021 Latency: out_valid asserted exactly one cycle after the in_valid cycle that completes the window.
REQ-022 frame_done pulses with out_valid when the completing sample is row ROWS-1, col COLS-1.
REQ-023 pool_result_k and out_idx hold their last values while out_valid is low.
REQ-024 in_valid gaps of any length permitted; no internal state changes while in_valid is low.
REQ-025 No backpressure; consumer shall accept every out_valid pulse.
REQ-026 Back-to-back frames without gap supported; row/col wrap starts the next frame with no in_sof required.

Reset
REQ-027 rst high at a rising edge: row, col, hold registers, line buffer contents treated as don't-care, pool_result_k = 0, out_idx = 0, out_valid = 0, frame_done = 0.
REQ-028 rst asserted mid-frame: partial frame abandoned; first in_valid after rst deasserts is row 0, col 0.
REQ-029 rst has priority over in_valid and in_sof in the same cycle; that sample is dropped.

Verification
REQ-030 Reset: rst high 2 cycles -> all outputs 0, out_valid 0, frame_done 0.
REQ-031 Single window: COLS=ROWS=24, in_sof + samples ch1 = 5, -3, 7, 2 at (0,0),(0,1),(1,0),(1,1) via full rows -> pool_result_1 = 7, out_idx = 0 one cycle after (1,1).
REQ-032 All-negative: every sample -100 on all channels for a full frame -> 144 out_valid pulses, all pool_result_k = 0, frame_done only on out_idx 143.
REQ-033 Width extremes: ch8 sample 2^67-1 in one window, others 0 -> pool_result_8 = 2^67-1 exact; sample -2^68 -> 0.
REQ-034 Gapped input: random in_valid duty 30% over a full ramp frame (x = row*24+col) -> outputs match continuous-input golden model, out_idx 0..143 in order.
REQ-035 Resync: in_sof asserted at row 5, col 9 of a frame -> no output from the abandoned window; next 144 outputs correct for the new frame; rst mid-frame gives the same result.
